// File: rtl/nts_tx_frame_writer_pkg.sv
// Shared state encodings and framing constants for the NTS TX frame writer.
package nts_tx_frame_writer_pkg;

  typedef enum logic [2:0] {
    ST_FILL   = 3'd0,
    ST_PAD    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_READY  = 3'd3,
    ST_SEND   = 3'd4,
    ST_FLUSH  = 3'd5
  } state_e;

  localparam int MIN_FRAME_WORDS = 3;
  localparam int PAD_BYTES       = 60;
  localparam int PAD_WORDS       = 8;
  localparam int PAD_LWDV        = 4;

endpackage

// File: rtl/nts_tx_frame_writer.sv
// Writes one engine frame into an extractor TX buffer and holds it until sent.
// Optional NTS_TX_WRITER_PAD_EN zero-pads short frames to 60 bytes instead of dropping them.
module nts_tx_frame_writer
  import nts_tx_frame_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [63:0]           i_data,
  input  logic                  i_last,
  input  logic [3:0]            i_bytes,
  input  logic                  i_abort,
  output logic                  o_drop,
  output logic                  o_buf_ready,
  input  logic                  i_buf_start,
  input  logic                  i_buf_stop,
  output logic [ADDR_WIDTH-1:0] o_buf_wr_addr,
  output logic                  o_buf_wr_en,
  output logic [63:0]           o_buf_wr_data,
  output logic [ADDR_WIDTH-1:0] o_buf_length,
  output logic [3:0]            o_buf_lwdv
);

  localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_MAX  = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d, cnt_inc;
  logic                  settle_q, settle_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [3:0]            lwdv_q, lwdv_d;
  logic                  drop_q, drop_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [63:0]           wr_data_q, wr_data_d;
  logic                  bad_bytes;

  // Keep the first nbytes wire bytes (MSB side) of the last word, zero the rest.
  function automatic logic [63:0] mask_last(input logic [63:0] data, input logic [3:0] nbytes);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++)
      if (i < int'(nbytes)) m[63-8*i -: 8] = 8'hff;
    return data & m;
  endfunction

  assign cnt_inc   = cnt_q + CNT_ONE;
  assign bad_bytes = (i_bytes == 4'd0) || (i_bytes > 4'd8);

`ifdef NTS_TX_WRITER_PAD_EN
  logic [ADDR_WIDTH+3:0] frame_bytes;
  assign frame_bytes = {cnt_q, 3'b000} + (ADDR_WIDTH+4)'(i_bytes);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    settle_d  = settle_q;
    len_d     = len_q;
    lwdv_d    = lwdv_q;
    drop_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      ST_FILL: begin
        if (i_abort) begin
          cnt_d  = '0;
          drop_d = (cnt_q != '0) || i_valid;
        end else if (i_valid) begin
          if (cnt_q == CNT_FULL) begin
            if (i_last) begin
              drop_d = 1'b1;
              cnt_d  = '0;
            end else begin
              state_d = ST_FLUSH;
            end
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q[ADDR_WIDTH-1:0];
            wr_data_d = i_last ? mask_last(i_data, i_bytes) : i_data;
            cnt_d     = cnt_inc;
            if (i_last) begin
              // A full buffer's length would wrap to 0, so it is treated as overflow.
              if (bad_bytes || (cnt_q == CNT_MAX)) begin
                drop_d = 1'b1;
                cnt_d  = '0;
`ifdef NTS_TX_WRITER_PAD_EN
              end else if (frame_bytes < (ADDR_WIDTH+4)'(PAD_BYTES)) begin
                len_d  = ADDR_WIDTH'(PAD_WORDS);
                lwdv_d = 4'(PAD_LWDV);
                if (cnt_inc >= (ADDR_WIDTH+1)'(PAD_WORDS)) begin
                  state_d  = ST_SETTLE;
                  settle_d = 1'b0;
                end else begin
                  state_d = ST_PAD;
                end
`else
              end else if (cnt_inc < (ADDR_WIDTH+1)'(MIN_FRAME_WORDS)) begin
                drop_d = 1'b1;
                cnt_d  = '0;
`endif
              end else begin
                state_d  = ST_SETTLE;
                settle_d = 1'b0;
                len_d    = cnt_inc[ADDR_WIDTH-1:0];
                lwdv_d   = i_bytes;
              end
            end
          end
        end
      end
`ifdef NTS_TX_WRITER_PAD_EN
      ST_PAD: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q[ADDR_WIDTH-1:0];
        wr_data_d = '0;
        cnt_d     = cnt_inc;
        if (cnt_q == (ADDR_WIDTH+1)'(PAD_WORDS - 1)) begin
          state_d  = ST_SETTLE;
          settle_d = 1'b0;
        end
      end
`endif
      // Two idle cycles let the extractor's registered memory write land before its first read.
      ST_SETTLE: begin
        settle_d = 1'b1;
        if (settle_q) state_d = ST_READY;
      end
      ST_READY: begin
        if (i_buf_start) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (i_buf_stop) begin
          state_d = ST_FILL;
          cnt_d   = '0;
        end
      end
      ST_FLUSH: begin
        if (i_abort || (i_valid && i_last)) begin
          state_d = ST_FILL;
          cnt_d   = '0;
          drop_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_FILL;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_q   <= ST_FILL;
      cnt_q     <= '0;
      settle_q  <= 1'b0;
      len_q     <= '0;
      lwdv_q    <= '0;
      drop_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      len_q     <= len_d;
      lwdv_q    <= lwdv_d;
      drop_q    <= drop_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign o_ready       = (state_q == ST_FILL) || (state_q == ST_FLUSH);
  assign o_buf_ready   = (state_q == ST_READY);
  assign o_drop        = drop_q;
  assign o_buf_wr_en   = wr_en_q;
  assign o_buf_wr_addr = wr_addr_q;
  assign o_buf_wr_data = wr_data_q;
  assign o_buf_length  = len_q;
  assign o_buf_lwdv    = lwdv_q;

endmodule
